// File: rtl/ps2_kbd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : ps2_kbd_sequencer_if
// Purpose  : Byte link to the PS/2 interface plus the key-event stream.
// Revision : 1.0 - initial release
// ============================================================================
interface ps2_kbd_sequencer_if;
    logic [7:0] tx_data;
    logic       write_data;
    logic [7:0] rx_data;
    logic       read_data;
    logic       busy;
    logic       err;
    logic       key_valid;
    logic       key_ready;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       key_overrun;

    modport master (
        output tx_data, write_data, key_valid, key_code, key_ext, key_break, key_overrun,
        input  rx_data, read_data, busy, err, key_ready
    );

    modport slave (
        input  tx_data, write_data, key_valid, key_code, key_ext, key_break, key_overrun,
        output rx_data, read_data, busy, err, key_ready
    );
endinterface
`default_nettype wire

// File: rtl/ps2_kbd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ps2_kbd_sequencer
// Purpose  : Keyboard bring-up, LED command sequencing with ACK/resend/retry,
//            and scancode-to-key-event parsing on a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_kbd_sequencer #(
    parameter int ACK_TIMEOUT = 2_500_000,
    parameter int BAT_TIMEOUT = 50_000_000,
    parameter int MAX_RETRY   = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    ps2_kbd_sequencer_if.master        bus,
    input  logic                       led_req,
    input  logic [2:0]                 led_val,
    output logic                       led_ack,
    output logic                       kbd_ready,
    output logic                       kbd_fail
);

    localparam int TMO_MAX = (ACK_TIMEOUT > BAT_TIMEOUT) ? ACK_TIMEOUT : BAT_TIMEOUT;
    localparam int TMO_W   = (TMO_MAX > 1) ? $clog2(TMO_MAX) : 1;
    localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TMO_W-1:0] ACK_LAST  = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] BAT_LAST  = TMO_W'(BAT_TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RETRY_MAX = RTY_W'(MAX_RETRY);

    localparam logic [2:0] ST_SEND     = 3'd0;
    localparam logic [2:0] ST_WAIT_TX  = 3'd1;
    localparam logic [2:0] ST_WAIT_ACK = 3'd2;
    localparam logic [2:0] ST_WAIT_BAT = 3'd3;
    localparam logic [2:0] ST_IDLE     = 3'd4;
    localparam logic [2:0] ST_FAIL     = 3'd5;

    // Return target: what follows an ACK of the current byte
    localparam logic [1:0] SEQ_INIT    = 2'd0;
    localparam logic [1:0] SEQ_LED_CMD = 2'd1;
    localparam logic [1:0] SEQ_LED_VAL = 2'd2;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_LED      = 8'hED;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;
    localparam logic [7:0] PFX_EXT      = 8'hE0;
    localparam logic [7:0] PFX_BRK      = 8'hF0;

    logic [2:0]       state;
    logic [1:0]       seq;
    logic [7:0]       cur_byte;
    logic [2:0]       led_lat;
    logic [RTY_W-1:0] retry_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             ext_flag;
    logic             brk_flag;

    logic in_resp;
    logic rsp_byte;
    logic to_parser;
    logic evt_form;
    logic tmo_hit;
    logic rx_ack;
    logic rx_resend;

    always_comb begin
        in_resp   = (state == ST_WAIT_ACK) || (state == ST_WAIT_BAT);
        rsp_byte  = (bus.rx_data == RSP_ACK) || (bus.rx_data == RSP_RESEND) ||
                    (bus.rx_data == RSP_BAT_OK) || (bus.rx_data == RSP_BAT_FAIL);
        to_parser = bus.read_data && !(in_resp && rsp_byte);
        evt_form  = to_parser && !bus.err &&
                    (bus.rx_data != PFX_EXT) && (bus.rx_data != PFX_BRK);
        tmo_hit   = (state == ST_WAIT_BAT) ? (tmo_cnt == BAT_LAST) : (tmo_cnt == ACK_LAST);
        rx_ack    = bus.read_data && (bus.rx_data == RSP_ACK);
        rx_resend = bus.read_data && (bus.rx_data == RSP_RESEND);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_SEND;
            seq            <= SEQ_INIT;
            cur_byte       <= CMD_RESET;
            led_lat        <= 3'b000;
            retry_cnt      <= '0;
            tmo_cnt        <= '0;
            bus.tx_data    <= 8'h00;
            bus.write_data <= 1'b0;
            led_ack        <= 1'b0;
            kbd_ready      <= 1'b0;
            kbd_fail       <= 1'b0;
        end else begin
            bus.write_data <= 1'b0;
            led_ack        <= 1'b0;
            case (state)
                ST_SEND: begin
                    if (!bus.busy) begin
                        bus.tx_data    <= cur_byte;
                        bus.write_data <= 1'b1;
                        state          <= ST_WAIT_TX;
                    end
                end
                ST_WAIT_TX: begin
                    if (!bus.busy) begin
                        tmo_cnt <= '0;
                        state   <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    // Counter parks on its last value so a timeout masked by a received byte fires next cycle
                    if (!tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
                    if (rx_ack) begin
                        retry_cnt <= '0;
                        case (seq)
                            SEQ_INIT: begin
                                tmo_cnt <= '0;
                                state   <= ST_WAIT_BAT;
                            end
                            SEQ_LED_CMD: begin
                                cur_byte <= {5'b00000, led_lat};
                                seq      <= SEQ_LED_VAL;
                                state    <= ST_SEND;
                            end
                            default: begin
                                led_ack <= 1'b1;
                                state   <= ST_IDLE;
                            end
                        endcase
                    end else if (rx_resend || bus.err || (tmo_hit && !bus.read_data)) begin
                        if (retry_cnt == RETRY_MAX) begin
                            kbd_ready <= 1'b0;
                            kbd_fail  <= 1'b1;
                            state     <= ST_FAIL;
                        end else begin
                            retry_cnt <= retry_cnt + 1'b1;
                            state     <= ST_SEND;
                        end
                    end
                end
                ST_WAIT_BAT: begin
                    if (!tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
                    if (bus.read_data && (bus.rx_data == RSP_BAT_OK)) begin
                        kbd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end else if ((bus.read_data && (bus.rx_data == RSP_BAT_FAIL)) ||
                                 (tmo_hit && !bus.read_data)) begin
                        kbd_ready <= 1'b0;
                        kbd_fail  <= 1'b1;
                        state     <= ST_FAIL;
                    end
                end
                ST_IDLE: begin
                    if (led_req && !led_ack) begin
                        led_lat   <= led_val;
                        cur_byte  <= CMD_LED;
                        seq       <= SEQ_LED_CMD;
                        retry_cnt <= '0;
                        state     <= ST_SEND;
                    end
                end
                ST_FAIL: begin
                    kbd_ready <= 1'b0;
                    kbd_fail  <= 1'b1;
                end
                default: begin
                    kbd_ready <= 1'b0;
                    kbd_fail  <= 1'b1;
                    state     <= ST_FAIL;
                end
            endcase
        end
    end

    // Parser and event register; a busy slot drops new events unless accepted this cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ext_flag        <= 1'b0;
            brk_flag        <= 1'b0;
            bus.key_valid   <= 1'b0;
            bus.key_code    <= 8'h00;
            bus.key_ext     <= 1'b0;
            bus.key_break   <= 1'b0;
            bus.key_overrun <= 1'b0;
        end else begin
            bus.key_overrun <= 1'b0;
            if (bus.err) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (to_parser) begin
                if (bus.rx_data == PFX_EXT) begin
                    ext_flag <= 1'b1;
                end else if (bus.rx_data == PFX_BRK) begin
                    brk_flag <= 1'b1;
                end else begin
                    ext_flag <= 1'b0;
                    brk_flag <= 1'b0;
                end
            end

            if (evt_form) begin
                if (!bus.key_valid || bus.key_ready) begin
                    bus.key_valid <= 1'b1;
                    bus.key_code  <= bus.rx_data;
                    bus.key_ext   <= ext_flag;
                    bus.key_break <= brk_flag;
                end else begin
                    bus.key_overrun <= 1'b1;
                end
            end else if (bus.key_ready) begin
                bus.key_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_kbd_sequencer
// Purpose  : Directed scenarios for init, LED updates, retries and key events.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_kbd_sequencer;

    localparam int ACK_TMO = 16;
    localparam int BAT_TMO = 64;
    localparam int RETRIES = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       led_req;
    logic [2:0] led_val;
    logic       led_ack;
    logic       kbd_ready;
    logic       kbd_fail;

    ps2_kbd_sequencer_if bus();

    ps2_kbd_sequencer #(
        .ACK_TIMEOUT (ACK_TMO),
        .BAT_TIMEOUT (BAT_TMO),
        .MAX_RETRY   (RETRIES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .led_req   (led_req),
        .led_val   (led_val),
        .led_ack   (led_ack),
        .kbd_ready (kbd_ready),
        .kbd_fail  (kbd_fail)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] wr_byte [0:255];
    int         wr_cyc  [0:255];
    int         wr_n     = 0;
    int         wr_rd    = 0;
    logic [9:0] evt_log [0:63];
    int         evt_n    = 0;
    int         ack_n    = 0;
    int         ovr_n    = 0;
    int         busy_cnt = 0;

    // Interface model: busy stays high for three cycles after each write strobe
    always @(negedge clk) begin
        if (bus.write_data === 1'b1) begin
            if (wr_n < 256) begin
                wr_byte[wr_n] = bus.tx_data;
                wr_cyc[wr_n]  = cyc;
            end
            wr_n++;
            busy_cnt = 3;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        bus.busy = (busy_cnt != 0);
        if (led_ack === 1'b1) ack_n++;
        if (bus.key_overrun === 1'b1) ovr_n++;
        if (bus.key_valid === 1'b1 && bus.key_ready === 1'b1) begin
            if (evt_n < 64) evt_log[evt_n] = {bus.key_code, bus.key_ext, bus.key_break};
            evt_n++;
        end
    end

    task automatic wait_write(input int bound, output logic [7:0] b, output int c, output bit ok);
        ok = 1'b0;
        b  = 8'h00;
        c  = 0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(posedge clk);
            #2;
            if (wr_rd < wr_n) begin
                b  = wr_byte[wr_rd];
                c  = wr_cyc[wr_rd];
                wr_rd++;
                ok = 1'b1;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data   = b;
        bus.read_data = 1'b1;
        @(negedge clk);
        bus.read_data = 1'b0;
    endtask

    task automatic request_led(input logic [2:0] v);
        led_val = v;
        @(negedge clk);
        led_req = 1'b1;
        @(negedge clk);
        led_req = 1'b0;
    endtask

    task automatic test_reset;
        logic [23:0] outs;
        reset         = 1'b0;
        led_req       = 1'b0;
        led_val       = 3'b000;
        bus.rx_data   = 8'h00;
        bus.read_data = 1'b0;
        bus.err       = 1'b0;
        bus.key_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        outs = {bus.write_data, bus.tx_data, led_ack, kbd_ready, kbd_fail, bus.key_valid,
                bus.key_overrun, bus.key_code, bus.key_ext, bus.key_break};
        checks++;
        if (outs !== 24'h000000) begin
            failures++;
            $display("FAIL reset_outputs: got %06h expected 000000", outs);
        end
        checks++;
        if (wr_n !== 0) begin
            failures++;
            $display("FAIL reset_no_write: got %0d writes expected 0", wr_n);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_init;
        logic [7:0] b;
        int         c;
        bit         ok;
        int         n0;
        n0 = wr_n;
        wait_write(10, b, c, ok);
        checks++;
        if (!ok || b !== 8'hFF) begin
            failures++;
            $display("FAIL init_cmd: got ok=%0d byte=%02h expected byte=ff", ok, b);
        end
        repeat (4) @(negedge clk);
        send_byte(8'hFA);
        repeat (3) @(negedge clk);
        send_byte(8'hAA);
        @(negedge clk);
        #1;
        checks++;
        if (kbd_ready !== 1'b1 || kbd_fail !== 1'b0) begin
            failures++;
            $display("FAIL init_ready: got ready=%b fail=%b expected ready=1 fail=0", kbd_ready, kbd_fail);
        end
        checks++;
        if (wr_n - n0 !== 1) begin
            failures++;
            $display("FAIL init_write_count: got %0d expected 1", wr_n - n0);
        end
        checks++;
        if (bus.key_valid !== 1'b0) begin
            failures++;
            $display("FAIL init_no_event: got key_valid=%b expected 0", bus.key_valid);
        end
    endtask

    task automatic test_led;
        logic [7:0] b;
        int         c;
        bit         ok;
        int         a0;
        request_led(3'b101);
        wait_write(10, b, c, ok);
        checks++;
        if (!ok || b !== 8'hED) begin
            failures++;
            $display("FAIL led_cmd: got ok=%0d byte=%02h expected byte=ed", ok, b);
        end
        repeat (4) @(negedge clk);
        send_byte(8'hFA);
        wait_write(10, b, c, ok);
        checks++;
        if (!ok || b !== 8'h05) begin
            failures++;
            $display("FAIL led_value: got ok=%0d byte=%02h expected byte=05", ok, b);
        end
        repeat (4) @(negedge clk);
        a0 = ack_n;
        send_byte(8'hFA);
        #1;
        checks++;
        if (led_ack !== 1'b1) begin
            failures++;
            $display("FAIL led_ack_latency: got %b expected 1 one cycle after ACK", led_ack);
        end
        @(negedge clk);
        #1;
        checks++;
        if (led_ack !== 1'b0) begin
            failures++;
            $display("FAIL led_ack_pulse: got %b expected 0 on second cycle", led_ack);
        end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (ack_n - a0 !== 1 || bus.key_valid !== 1'b0 || kbd_ready !== 1'b1) begin
            failures++;
            $display("FAIL led_done: got acks=%0d key_valid=%b ready=%b expected 1 0 1",
                     ack_n - a0, bus.key_valid, kbd_ready);
        end
    endtask

    task automatic test_resend;
        logic [7:0] exp_b [0:5];
        logic [7:0] rsp_b [0:5];
        logic [7:0] b;
        int         c;
        bit         ok;
        int         a0;
        // Two resends per byte: retry count must restart for the value byte
        exp_b[0] = 8'hED; exp_b[1] = 8'hED; exp_b[2] = 8'hED;
        exp_b[3] = 8'h02; exp_b[4] = 8'h02; exp_b[5] = 8'h02;
        rsp_b[0] = 8'hFE; rsp_b[1] = 8'hFE; rsp_b[2] = 8'hFA;
        rsp_b[3] = 8'hFE; rsp_b[4] = 8'hFE; rsp_b[5] = 8'hFA;
        a0 = ack_n;
        request_led(3'b010);
        for (int i = 0; i < 6; i++) begin
            wait_write(12, b, c, ok);
            checks++;
            if (!ok || b !== exp_b[i]) begin
                failures++;
                $display("FAIL resend_seq[%0d]: got ok=%0d byte=%02h expected byte=%02h", i, ok, b, exp_b[i]);
            end
            repeat (4) @(negedge clk);
            send_byte(rsp_b[i]);
        end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (ack_n - a0 !== 1 || kbd_fail !== 1'b0 || kbd_ready !== 1'b1) begin
            failures++;
            $display("FAIL resend_done: got acks=%0d fail=%b ready=%b expected 1 0 1",
                     ack_n - a0, kbd_fail, kbd_ready);
        end
        wait_write(30, b, c, ok);
        checks++;
        if (ok) begin
            failures++;
            $display("FAIL resend_extra_write: got byte=%02h expected none", b);
        end
    endtask

    task automatic test_scancodes;
        logic [7:0] bytes [0:6];
        logic [9:0] exp_e [0:3];
        int         e0;
        bytes[0] = 8'h1C; bytes[1] = 8'hE0; bytes[2] = 8'h75;
        bytes[3] = 8'hE0; bytes[4] = 8'hF0; bytes[5] = 8'h75; bytes[6] = 8'hE0;
        exp_e[0] = {8'h1C, 2'b00};
        exp_e[1] = {8'h75, 2'b10};
        exp_e[2] = {8'h75, 2'b11};
        exp_e[3] = {8'h1C, 2'b00};
        @(negedge clk);
        bus.key_ready = 1'b1;
        e0 = evt_n;
        for (int i = 0; i < 7; i++) send_byte(bytes[i]);
        // Receive error must discard the pending E0 prefix
        @(negedge clk);
        bus.err = 1'b1;
        @(negedge clk);
        bus.err = 1'b0;
        send_byte(8'h1C);
        repeat (3) @(negedge clk);
        checks++;
        if (evt_n - e0 !== 4) begin
            failures++;
            $display("FAIL scan_count: got %0d events expected 4", evt_n - e0);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (evt_log[e0 + i] !== exp_e[i]) begin
                failures++;
                $display("FAIL scan_event[%0d]: got {%02h,%b,%b} expected {%02h,%b,%b}", i,
                         evt_log[e0 + i][9:2], evt_log[e0 + i][1], evt_log[e0 + i][0],
                         exp_e[i][9:2], exp_e[i][1], exp_e[i][0]);
            end
        end
        bus.key_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        int o0;
        bus.key_ready = 1'b0;
        o0 = ovr_n;
        send_byte(8'h1C);
        #1;
        checks++;
        if (bus.key_valid !== 1'b1 || bus.key_code !== 8'h1C) begin
            failures++;
            $display("FAIL bp_first: got valid=%b code=%02h expected 1 1c", bus.key_valid, bus.key_code);
        end
        send_byte(8'h32);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bus.key_valid !== 1'b1 || bus.key_code !== 8'h1C || bus.key_ext !== 1'b0 ||
            bus.key_break !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold: got valid=%b code=%02h ext=%b brk=%b expected 1 1c 0 0",
                     bus.key_valid, bus.key_code, bus.key_ext, bus.key_break);
        end
        checks++;
        if (ovr_n - o0 !== 1) begin
            failures++;
            $display("FAIL bp_overrun: got %0d pulses expected 1", ovr_n - o0);
        end
    endtask

    task automatic test_back_to_back;
        int o0;
        o0 = ovr_n;
        @(negedge clk);
        bus.rx_data   = 8'h2B;
        bus.read_data = 1'b1;
        bus.key_ready = 1'b1;
        @(negedge clk);
        bus.read_data = 1'b0;
        bus.key_ready = 1'b0;
        #1;
        checks++;
        if (bus.key_valid !== 1'b1 || bus.key_code !== 8'h2B) begin
            failures++;
            $display("FAIL b2b_replace: got valid=%b code=%02h expected 1 2b", bus.key_valid, bus.key_code);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (ovr_n - o0 !== 0) begin
            failures++;
            $display("FAIL b2b_no_overrun: got %0d pulses expected 0", ovr_n - o0);
        end
        bus.key_ready = 1'b1;
        @(negedge clk);
        bus.key_ready = 1'b0;
        #1;
        checks++;
        if (bus.key_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: got valid=%b expected 0", bus.key_valid);
        end
    endtask

    task automatic test_ack_fail;
        logic [7:0] b;
        int         c;
        bit         ok;
        request_led(3'b111);
        for (int i = 0; i < RETRIES + 1; i++) begin
            wait_write(12, b, c, ok);
            checks++;
            if (!ok || b !== 8'hED) begin
                failures++;
                $display("FAIL fail_send[%0d]: got ok=%0d byte=%02h expected byte=ed", i, ok, b);
            end
            repeat (4) @(negedge clk);
            send_byte(8'hFE);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (kbd_fail !== 1'b1 || kbd_ready !== 1'b0) begin
            failures++;
            $display("FAIL fail_flags: got fail=%b ready=%b expected 1 0", kbd_fail, kbd_ready);
        end
        wait_write(40, b, c, ok);
        checks++;
        if (ok) begin
            failures++;
            $display("FAIL fail_extra_write: got byte=%02h expected none", b);
        end
    endtask

    task automatic test_reset_mid;
        bus.key_ready = 1'b0;
        send_byte(8'h4D);
        #1;
        checks++;
        if (bus.key_valid !== 1'b1 || bus.key_code !== 8'h4D) begin
            failures++;
            $display("FAIL fail_parser: got valid=%b code=%02h expected 1 4d", bus.key_valid, bus.key_code);
        end
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.key_valid !== 1'b0 || kbd_fail !== 1'b0 || kbd_ready !== 1'b0) begin
            failures++;
            $display("FAIL midreset_clear: got valid=%b fail=%b ready=%b expected 0 0 0",
                     bus.key_valid, kbd_fail, kbd_ready);
        end
        repeat (2) @(negedge clk);
        wr_rd = wr_n;
        reset = 1'b1;
        test_init();
    endtask

    task automatic test_timeout;
        logic [7:0] b;
        int         c0;
        int         c1;
        bit         ok;
        int         sends;
        int         n0;
        request_led(3'b001);
        wait_write(10, b, c0, ok);
        checks++;
        if (!ok || b !== 8'hED) begin
            failures++;
            $display("FAIL tmo_first: got ok=%0d byte=%02h expected byte=ed", ok, b);
        end
        wait_write(40, b, c1, ok);
        // 4 cycles until busy drops, 16 timeout cycles, 1 cycle to reissue the strobe
        checks++;
        if (!ok || b !== 8'hED || c1 - c0 !== 21) begin
            failures++;
            $display("FAIL tmo_resend: got ok=%0d byte=%02h gap=%0d expected byte=ed gap=21",
                     ok, b, c1 - c0);
        end
        sends = 2;
        for (int i = 0; i < 2; i++) begin
            wait_write(40, b, c1, ok);
            if (ok && b === 8'hED) sends++;
        end
        checks++;
        if (sends !== 4) begin
            failures++;
            $display("FAIL tmo_sends: got %0d sends expected 4", sends);
        end
        n0 = wr_n;
        repeat (40) @(negedge clk);
        #1;
        checks++;
        if (kbd_fail !== 1'b1 || kbd_ready !== 1'b0 || wr_n !== n0) begin
            failures++;
            $display("FAIL tmo_fail: got fail=%b ready=%b extra_writes=%0d expected 1 0 0",
                     kbd_fail, kbd_ready, wr_n - n0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_init();
        test_led();
        test_resend();
        test_scancodes();
        test_backpressure();
        test_back_to_back();
        test_ack_fail();
        test_reset_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_kbd_sequencer.md
# ps2_kbd_sequencer

Command sequencer and scancode parser between the game logic and the PS/2 byte interface (`Ps2Interface`). After reset it brings the keyboard up (reset command, ACK, self-test result). It then serves LED-update requests (0xED + value) with ACK/resend/retry handling, and turns received scancode bytes into single key events (make/break, extended) delivered on a valid/ready handshake.

## Interface
- `ACK_TIMEOUT`, 2_500_000: clk cycles to wait for 0xFA/0xFE after a transmitted byte completes.
- `BAT_TIMEOUT`, 50_000_000: clk cycles to wait for 0xAA after the reset command is ACKed.
- `MAX_RETRY`, 3: resends allowed per byte before declaring failure.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `tx_data`  out  8  byte to send to the interface.
- `write_data`  out  1  one-cycle send strobe.
- `rx_data`  in  8  received byte.
- `read_data`  in  1  one-cycle strobe; `rx_data` is valid in the same cycle.
- `busy`  in  1  interface is transmitting.
- `err`  in  1  one-cycle transmit/receive error.
- `led_req`  in  1  request an LED update (level; sampled in IDLE).
- `led_val`  in  3  {caps, num, scroll} LED bits.
- `led_ack`  out  1  one-cycle pulse when the LED update is ACKed.
- `kbd_ready`  out  1  init complete; stays high until reset or failure.
- `kbd_fail`  out  1  sticky failure flag; cleared only by reset.
- `key_valid`  out  1  key event pending.
- `key_ready`  in  1  consumer accepts the event.
- `key_code`  out  8  scancode.
- `key_ext`  out  1  event was preceded by 0xE0.
- `key_break`  out  1  event is a release (preceded by 0xF0).
- `key_overrun`  out  1  one-cycle pulse when an event is dropped.

## Operation
- States: SEND, WAIT_TX, WAIT_ACK, WAIT_BAT, IDLE, FAIL. A "current byte" register and a return target sequence the command bytes.
- Init sequence: send 0xFF, then WAIT_ACK, then WAIT_BAT.
  - 0xAA sets `kbd_ready` and enters IDLE.
  - 0xFC or BAT timeout enters FAIL.
- IDLE with `led_req`=1: latch `led_val`, send 0xED, ACK, send {5'b0, led_val}, ACK, pulse `led_ack`, return to IDLE. `led_req` is ignored outside IDLE.
- SEND: wait until `busy`=0, drive `tx_data`, pulse `write_data` for 1 cycle, go to WAIT_TX.
- WAIT_TX: wait for `busy` to fall, then go to WAIT_ACK and clear the timeout counter.
- WAIT_ACK handling:
  - 0xFA: advance to the next byte.
  - 0xFE, `err`, or timeout: retry counter +1, resend the same byte. If this exceeds MAX_RETRY, go to FAIL.
  - The retry counter clears on each new byte.
- FAIL: `kbd_ready`=0 and `kbd_fail`=1. The block stays in FAIL until reset, and the parser keeps running.
- Bytes received in WAIT_ACK/WAIT_BAT other than 0xFA/0xFE/0xFC/0xAA go to the parser. In all other states every byte goes to the parser.
- Parser rules:
  - 0xE0 sets ext_flag.
  - 0xF0 sets brk_flag.
  - Any other byte forms an event {code, ext_flag, brk_flag}, then both flags clear.
  - `err` clears both flags.
- Event output:
  - An event is held (code/ext/break stable) while `key_valid`=1 and `key_ready`=0.
  - If a new event forms while one is still pending, the new event is dropped and `key_overrun` pulses.
  - If `key_ready`=1 in the same cycle a new event forms, the new event replaces the accepted one and `key_valid` stays 1.

## Timing
- Reset values: all outputs 0. The state machine starts in SEND with byte 0xFF; counters and flags are 0.
- Release from reset: `write_data` pulses no earlier than the 1st cycle after `reset` deasserts, and only once `busy`=0.
- `read_data` to `key_valid`: 1 cycle, registered.
- Final 0xFA strobe to `led_ack` pulse: 1 cycle. The next `led_req` is accepted no earlier than the following cycle.
- Timeout counter:
  - Increments each cycle in WAIT_ACK/WAIT_BAT.
  - Fires at count == ACK_TIMEOUT−1 (or BAT_TIMEOUT−1).
  - Width is clog2 of the larger timeout.
- Simultaneous `read_data` and timeout in the same cycle: the received byte wins.
- `reset` asserted mid-transaction: return to the reset state immediately and drop any pending event.

## Test plan
- Init: return 0xFA, then 0xAA, after `write_data` of 0xFF -> `kbd_ready`=1, `kbd_fail`=0, exactly one `write_data`.
- LED update: `led_val`=3'b101 -> `tx_data` is 0xED then 0x05, each ACKed with 0xFA -> one `led_ack` pulse, then back to IDLE.
- Resend: answer the first 0xED with 0xFE twice, then 0xFA -> 0xED is sent 3 times total, no failure. With 4 consecutive 0xFE (MAX_RETRY=3) -> `kbd_fail`=1.
- Timeout: with ACK_TIMEOUT=16 and no response -> a resend after 16 cycles; after 4 timeouts -> FAIL.
- Scancodes: bytes 0x1C; 0xE0,0x75; 0xE0,0xF0,0x75 with `key_ready`=1 -> events {1C,0,0}, {75,1,0}, {75,1,1}.
- Backpressure: `key_ready`=0 and bytes 0x1C, 0x32 -> event 0x1C is held, `key_overrun` pulses once, 0x32 is lost.
